// File: rtl/imem_fetch_ctrl.sv
`timescale 1ns/1ps
// imem_fetch_ctrl
// Instruction fetch controller for the LEGv8 pipeline. It holds the fetch
// PC and reads the combinational instruction ROM once per cycle into a
// small prefetch queue. The head of the queue goes to decode over a
// valid/ready handshake. Taken branches flush the queue and redirect fetch.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          leave IDLE and begin fetching
//   imem_addr      ROM word address, fetch_pc[ADDR_W+1:2]
//   imem_q         ROM read data, combinational from imem_addr
//   redirect_valid taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc    redirect target byte address
//   inst_valid     queue head valid
//   inst_ready     decode accepts the head this cycle
//   inst_data      head instruction
//   inst_pc        head byte PC
//   halted         fetch_pc has left the ROM range
//   count          queue occupancy
module imem_fetch_ctrl #(
    parameter int          N        = 32,
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 7,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [N-1:0]             imem_q,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [N-1:0]             inst_data,
    output logic [63:0]              inst_pc,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state, state_nxt;
    logic [63:0]        fetch_pc;
    logic [N-1:0]       q_data [DEPTH];
    logic [63:0]        q_pc   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   cnt;

    logic pc_in_range, tgt_in_range, run_en, pop, fetch, not_full;

    // Any address bit above the ROM word range means the PC is out of range.
    assign pc_in_range  = ~|fetch_pc[63:ADDR_W+2];
    assign tgt_in_range = ~|redirect_pc[63:ADDR_W+2];

    assign imem_addr  = fetch_pc[ADDR_W+1:2];
    assign inst_valid = (cnt != '0);
    assign inst_data  = q_data[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign count      = cnt;

    assign pop      = inst_valid & inst_ready;
    assign not_full = (cnt < CNT_W'(DEPTH));
    // A full queue may still accept a push when the head leaves the same cycle.
    assign fetch    = run_en & pc_in_range & (not_full | pop) & ~redirect_valid;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; redirect outranks start and the halt check
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && start) state_nxt = RUN;
            end
            RUN: begin
                if (redirect_valid)    state_nxt = tgt_in_range ? RUN : HALT;
                else if (!pc_in_range) state_nxt = HALT;
            end
            HALT: begin
                if (redirect_valid && tgt_in_range) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        run_en = (state == RUN);
        halted = (state == HALT);
    end

    // Fetch PC: redirect target is word-aligned by dropping the low bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC & ~64'h3;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~64'h3;
        end else if (fetch) begin
            fetch_pc <= fetch_pc + 64'd4;
        end
    end

    // Prefetch queue control; a redirect empties it regardless of push/pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (fetch) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({fetch, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Prefetch queue storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (fetch) begin
            q_data[wr_ptr] <= imem_q;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam int N      = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic [N-1:0]      imem_q;
    logic              redirect_valid = 1'b0;
    logic [63:0]       redirect_pc = '0;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [N-1:0]      inst_data;
    logic [63:0]       inst_pc;
    logic              halted;
    logic [CNT_W-1:0]  count;

    logic [N-1:0] rom [1 << ADDR_W];
    assign imem_q = rom[imem_addr];

    imem_fetch_ctrl #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .imem_addr(imem_addr),
        .imem_q(imem_q), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 fetching, 2 stopped out of range
    typedef struct packed { logic [63:0] pc; logic [N-1:0] d; } ent_t;
    ent_t        mq[$];
    int          mmode;
    logic [63:0] mpc;

    function automatic bit in_rom(input logic [63:0] a);
        return (a >> (ADDR_W + 2)) == 64'd0;
    endfunction

    task automatic model_reset();
        mq.delete();
        mmode = 0;
        mpc   = 64'h0;
    endtask

    task automatic model_step(input logic s, input logic rv, input logic [63:0] rpc, input logic rdy);
        bit popped, inr, fetched;
        popped  = (mq.size() > 0) && rdy;
        inr     = in_rom(mpc);
        fetched = (mmode == 1) && inr && ((mq.size() < DEPTH) || popped) && !rv;
        if (popped) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc = {rpc[63:2], 2'b00};
            if (mmode != 0) mmode = in_rom(rpc) ? 1 : 2;
        end else begin
            if (fetched) begin
                mq.push_back('{pc: mpc, d: rom[(mpc >> 2) % (1 << ADDR_W)]});
                mpc = mpc + 64'd4;
            end
            if (mmode == 0 && s) mmode = 1;
            else if (mmode == 1 && !inr) mmode = 2;
        end
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("inst_valid", 64'(inst_valid), 64'(mq.size() != 0));
            check("count", 64'(count), 64'(mq.size()));
            check("halted", 64'(halted), 64'(mmode == 2));
            check("imem_addr", 64'(imem_addr), 64'((mpc >> 2) % (1 << ADDR_W)));
            if (mq.size() != 0) begin
                check("inst_pc", inst_pc, mq[0].pc);
                check("inst_data", 64'(inst_data), 64'(mq[0].d));
            end
        end
    end

    // Drive inputs for one cycle, let the model see the same edge, return at edge+1
    task automatic tick(input logic s, input logic rv, input logic [63:0] rpc, input logic rdy);
        start = s; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
        @(posedge clk);
        model_step(s, rv, rpc, rdy);
        #1;
    endtask

    // Called at edge+1; asserts reset mid-cycle, releases on a negedge,
    // and returns at edge+1 with checking re-enabled.
    task automatic do_reset();
        #3;
        chk_en = 1'b0;
        reset_n = 1'b0;
        start = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        #1;
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_pc", inst_pc, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #6;
        chk_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = $urandom;
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = 32'hf8010003;
        rom[29] = 32'hb40000a0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Streaming with decode always ready: one per cycle, count held at 1
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("s1_pc0", inst_pc, 64'h0);
        check("s1_d0", 64'(inst_data), 64'hf8000001);
        check("s1_cnt", 64'(count), 64'd1);
        tick(0, 0, 0, 1);
        check("s1_pc1", inst_pc, 64'h4);
        check("s1_d1", 64'(inst_data), 64'hf8008002);
        tick(0, 0, 0, 1);
        check("s1_pc2", inst_pc, 64'h8);
        check("s1_d2", 64'(inst_data), 64'hf8010003);
        check("s1_cnt2", 64'(count), 64'd1);

        // Backpressure: fill, then drain in order
        do_reset();
        tick(1, 0, 0, 0);
        repeat (10) tick(0, 0, 0, 0);
        check("bp_cnt", 64'(count), 64'd4);
        check("bp_addr", 64'(imem_addr), 64'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_order", inst_pc, 64'(i * 4));
            tick(0, 0, 0, 1);
        end

        // Redirect while full and popping
        do_reset();
        tick(1, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 0);
        check("rd_full", 64'(count), 64'd4);
        tick(0, 1, 64'h74, 1);
        check("rd_cnt0", 64'(count), 64'd0);
        check("rd_valid0", 64'(inst_valid), 64'd0);
        tick(0, 0, 0, 1);
        check("rd_pc", inst_pc, 64'h74);
        check("rd_data", 64'(inst_data), 64'hb40000a0);

        // Run off the end of the ROM, then recover
        tick(0, 1, 64'h1f0, 1);
        repeat (4) tick(0, 0, 0, 1);
        check("end_pc", inst_pc, 64'h1fc);
        check("end_data", 64'(inst_data), 64'(rom[127]));
        tick(0, 0, 0, 1);
        check("end_halt", 64'(halted), 64'd1);
        check("end_valid", 64'(inst_valid), 64'd0);
        repeat (3) tick(0, 0, 0, 1);
        check("end_nopush", 64'(count), 64'd0);
        tick(0, 1, 64'h0, 1);
        check("rec_halt", 64'(halted), 64'd0);
        tick(0, 0, 0, 1);
        check("rec_pc", inst_pc, 64'h0);
        check("rec_data", 64'(inst_data), 64'hf8000001);

        // Misaligned out-of-range redirect
        tick(0, 0, 0, 0);
        tick(0, 1, 64'h203, 0);
        check("oor_halt", 64'(halted), 64'd1);
        check("oor_addr", 64'(imem_addr), 64'd0);
        repeat (3) tick(0, 0, 0, 1);
        check("oor_valid", 64'(inst_valid), 64'd0);

        // Reset with three entries queued, then confirm start is required
        do_reset();
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        check("mr_cnt3", 64'(count), 64'd3);
        do_reset();
        repeat (5) tick(0, 0, 0, 1);
        check("mr_idle", 64'(count), 64'd0);

        // Randomized traffic
        do_reset();
        tick(1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic s, rv, rdy;
            logic [63:0] t;
            s   = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       t = 64'h200 + 64'($urandom_range(0, 255));
                1:       t = {32'($urandom), 32'($urandom)};
                2, 3:    t = 64'($urandom_range(480, 511));
                default: t = 64'($urandom_range(0, 511));
            endcase
            tick(s, rv, t, rdy);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
